// File: rtl/char_renderer.sv
// Character renderer: fetches one glyph from an external combinational ROM
// and emits its pixels in raster order as plot strobes. Each glyph pixel is
// magnified by m = req_scale+1, and the framebuffer can apply back-pressure.
module char_renderer #(
    parameter int GLYPH_W = 8,
    parameter int GLYPH_H = 8,
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int COLOR_W = 3,
    parameter int SCALE_W = 2
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [7:0]                 req_char,
    input  logic [X_W-1:0]             req_x,
    input  logic [Y_W-1:0]             req_y,
    input  logic [COLOR_W-1:0]         req_fg,
    input  logic [COLOR_W-1:0]         req_bg,
    input  logic                       req_opaque,
    input  logic [SCALE_W-1:0]         req_scale,
    output logic [7:0]                 glyph_code,
    input  logic [GLYPH_W*GLYPH_H-1:0] glyph_bits,
    output logic                       plot,
    output logic [X_W-1:0]             plot_x,
    output logic [Y_W-1:0]             plot_y,
    output logic [COLOR_W-1:0]         plot_color,
    input  logic                       plot_stall,
    output logic                       busy,
    output logic                       done
);

    localparam int CW = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
    localparam int RW = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
    localparam int IW = (GLYPH_W * GLYPH_H > 1) ? $clog2(GLYPH_W * GLYPH_H) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;

    state_t                     state;
    logic [X_W-1:0]             x_r;
    logic [Y_W-1:0]             y_r;
    logic [COLOR_W-1:0]         fg_r, bg_r;
    logic                       opaque_r;
    logic [SCALE_W-1:0]         scale_r;
    logic [GLYPH_W*GLYPH_H-1:0] glyph_r;

    // Counters address the pixel currently presented on the plot outputs;
    // row 0 is the top glyph row and col 0 the leftmost column.
    logic [RW-1:0]      row, n_row, t_row;
    logic [CW-1:0]      col, n_col, t_col;
    logic [SCALE_W-1:0] sy, sx, n_sy, n_sx, t_sy, t_sx;
    logic               sx_last, col_last, sy_last, row_last, last_pix;

    logic [GLYPH_W*GLYPH_H-1:0] t_glyph;
    logic [IW-1:0]              bit_idx;
    logic                       t_bit, t_plot;
    logic [X_W-1:0]             t_x;
    logic [Y_W-1:0]             t_y;
    logic [COLOR_W-1:0]         t_color;
    int                         mag, sum_x, sum_y;

    // Next-pixel computation: in LOAD it targets pixel 0 using the ROM data
    // directly, in DRAW it targets the successor of the current pixel.
    always_comb begin
        sx_last  = (sx == scale_r);
        col_last = (col == CW'(GLYPH_W - 1));
        sy_last  = (sy == scale_r);
        row_last = (row == RW'(GLYPH_H - 1));
        last_pix = sx_last && col_last && sy_last && row_last;

        n_sx  = sx_last ? '0 : sx + 1'b1;
        n_col = sx_last ? (col_last ? '0 : col + 1'b1) : col;
        n_sy  = (sx_last && col_last) ? (sy_last ? '0 : sy + 1'b1) : sy;
        n_row = (sx_last && col_last && sy_last) ? row + 1'b1 : row;

        if (state == LOAD) begin
            t_glyph = glyph_bits;
            t_row   = '0;
            t_col   = '0;
            t_sy    = '0;
            t_sx    = '0;
        end else begin
            t_glyph = glyph_r;
            t_row   = n_row;
            t_col   = n_col;
            t_sy    = n_sy;
            t_sx    = n_sx;
        end

        bit_idx = IW'(GLYPH_W * (GLYPH_H - 1 - int'(t_row)) + (GLYPH_W - 1 - int'(t_col)));
        t_bit   = t_glyph[bit_idx];
        t_plot  = t_bit || opaque_r;
        t_color = t_bit ? fg_r : bg_r;

        mag   = int'(scale_r) + 1;
        sum_x = int'(x_r) + int'(t_col) * mag + int'(t_sx);
        sum_y = int'(y_r) + int'(t_row) * mag + int'(t_sy);
        t_x   = X_W'(sum_x);
        t_y   = Y_W'(sum_y);
    end

    // Control FSM; every output is a register so nothing combinational
    // reaches the ports from the request or stall inputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            x_r        <= '0;
            y_r        <= '0;
            fg_r       <= '0;
            bg_r       <= '0;
            opaque_r   <= 1'b0;
            scale_r    <= '0;
            glyph_r    <= '0;
            glyph_code <= '0;
            row        <= '0;
            col        <= '0;
            sy         <= '0;
            sx         <= '0;
            plot       <= 1'b0;
            plot_x     <= '0;
            plot_y     <= '0;
            plot_color <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            req_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        x_r        <= req_x;
                        y_r        <= req_y;
                        fg_r       <= req_fg;
                        bg_r       <= req_bg;
                        opaque_r   <= req_opaque;
                        scale_r    <= req_scale;
                        glyph_code <= req_char;
                        busy       <= 1'b1;
                        req_ready  <= 1'b0;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    glyph_r    <= glyph_bits;
                    row        <= '0;
                    col        <= '0;
                    sy         <= '0;
                    sx         <= '0;
                    plot       <= t_plot;
                    plot_x     <= t_x;
                    plot_y     <= t_y;
                    plot_color <= t_color;
                    state      <= DRAW;
                end
                DRAW: begin
                    // A stall only matters while a pixel is actually offered.
                    if (!(plot && plot_stall)) begin
                        if (last_pix) begin
                            plot  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            row        <= n_row;
                            col        <= n_col;
                            sy         <= n_sy;
                            sx         <= n_sx;
                            plot       <= t_plot;
                            plot_x     <= t_x;
                            plot_y     <= t_y;
                            plot_color <= t_color;
                        end
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_char_renderer.sv
// Directed bench for char_renderer: a reference model pushes the expected
// pixel stream (position, colour, cycle) into a scoreboard queue when a
// request is issued, and each offered pixel is popped and compared.
module tb_char_renderer;

    localparam int GW = 8;
    localparam int GH = 8;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CLW = 3;
    localparam int SW = 2;

    logic              clock = 1'b0;
    logic              resetn = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [7:0]        req_char = '0;
    logic [XW-1:0]     req_x = '0;
    logic [YW-1:0]     req_y = '0;
    logic [CLW-1:0]    req_fg = '0;
    logic [CLW-1:0]    req_bg = '0;
    logic              req_opaque = 1'b0;
    logic [SW-1:0]     req_scale = '0;
    logic [7:0]        glyph_code;
    logic [GW*GH-1:0]  glyph_bits;
    logic              plot;
    logic [XW-1:0]     plot_x;
    logic [YW-1:0]     plot_y;
    logic [CLW-1:0]    plot_color;
    logic              plot_stall = 1'b0;
    logic              busy;
    logic              done;

    typedef struct {
        int x;
        int y;
        int c;
        int cyc;
    } pix_t;

    pix_t exp_q[$];
    int   exp_done;
    int   checks = 0;
    int   errors = 0;

    char_renderer dut (
        .clock(clock), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_char(req_char), .req_x(req_x), .req_y(req_y),
        .req_fg(req_fg), .req_bg(req_bg), .req_opaque(req_opaque),
        .req_scale(req_scale),
        .glyph_code(glyph_code), .glyph_bits(glyph_bits),
        .plot(plot), .plot_x(plot_x), .plot_y(plot_y), .plot_color(plot_color),
        .plot_stall(plot_stall), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    // Bench glyph ROM: 0 = blank, 1 = solid, 2 = top-left pixel only.
    always_comb begin
        case (glyph_code)
            8'd1:    glyph_bits = {(GW*GH){1'b1}};
            8'd2:    glyph_bits = {1'b1, {(GW*GH-1){1'b0}}};
            default: glyph_bits = '0;
        endcase
    end

    function automatic int rom_bit(input int code, input int idx);
        if (code == 1) return 1;
        if (code == 2) return (idx == GW*GH-1) ? 1 : 0;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference model: expected plots in raster order with the cycle
    // (counted from the accept edge, LOAD = cycle 1) in which each appears.
    task automatic build(input int code, input int x, input int y, input int fg,
                         input int bg, input int opq, input int scale,
                         input int stall_at, input int stall_len);
        int m, k, npush, r, c, b;
        pix_t p;
        m = scale + 1;
        k = 0;
        npush = 0;
        exp_q.delete();
        for (int row = 0; row < GH; row++)
            for (int sy = 0; sy < m; sy++)
                for (int col = 0; col < GW; col++)
                    for (int sx = 0; sx < m; sx++) begin
                        r = GH - 1 - row;
                        c = GW - 1 - col;
                        b = rom_bit(code, GW*r + c);
                        if (b != 0 || opq != 0) begin
                            p.x = (x + col*m + sx) % (1 << XW);
                            p.y = (y + row*m + sy) % (1 << YW);
                            p.c = (b != 0) ? fg : bg;
                            p.cyc = k + 2 + ((stall_at > 0 && npush >= stall_at) ? stall_len : 0);
                            exp_q.push_back(p);
                            npush++;
                        end
                        k++;
                    end
        exp_done = k + 2 + ((stall_at > 0) ? stall_len : 0);
    endtask

    task automatic run(input string tag, input int code, input int x, input int y,
                       input int fg, input int bg, input int opq, input int scale,
                       input int stall_at, input int stall_len, input int inject_at);
        int cyc, got_done, stall_left, nplots, extra_done;
        logic prev_stall;
        int hx, hy, hc;
        pix_t p;
        build(code, x, y, fg, bg, opq, scale, stall_at, stall_len);
        @(negedge clock);
        chk({tag, " ready before"}, req_ready, 1);
        req_valid  = 1'b1;
        req_char   = 8'(code);
        req_x      = XW'(x);
        req_y      = YW'(y);
        req_fg     = CLW'(fg);
        req_bg     = CLW'(bg);
        req_opaque = opq[0];
        req_scale  = SW'(scale);
        @(posedge clock);
        #1;
        req_valid  = 1'b0;
        // Scramble request fields: the captured copy must be used.
        req_x      = ~req_x;
        req_y      = ~req_y;
        req_fg     = ~req_fg;
        req_bg     = ~req_bg;
        req_opaque = ~req_opaque;
        req_scale  = ~req_scale;
        cyc = 0; got_done = 0; stall_left = stall_len; nplots = 0;
        hx = 0; hy = 0; hc = 0;
        while (got_done == 0 && cyc < 1200) begin
            @(negedge clock);
            cyc++;
            prev_stall = plot_stall;
            if (cyc == 1) begin
                chk({tag, " load busy"}, busy, 1);
                chk({tag, " load ready"}, req_ready, 0);
                chk({tag, " load plot"}, plot, 0);
                chk({tag, " glyph_code"}, glyph_code, code);
            end
            if (plot) begin
                if (prev_stall) begin
                    chk({tag, " held x"}, plot_x, hx);
                    chk({tag, " held y"}, plot_y, hy);
                    chk({tag, " held color"}, plot_color, hc);
                end else if (exp_q.size() == 0) begin
                    chk({tag, " unexpected plot"}, 1, 0);
                end else begin
                    p = exp_q.pop_front();
                    chk({tag, " plot x"}, plot_x, p.x);
                    chk({tag, " plot y"}, plot_y, p.y);
                    chk({tag, " plot color"}, plot_color, p.c);
                    chk({tag, " plot cycle"}, cyc, p.cyc);
                    hx = p.x; hy = p.y; hc = p.c;
                    nplots++;
                end
            end
            if (plot && nplots == stall_at && stall_left > 0) begin
                plot_stall = 1'b1;
                stall_left--;
            end else begin
                plot_stall = 1'b0;
            end
            if (cyc == inject_at) begin
                req_valid = 1'b1;
                req_char  = 8'd0;
                req_opaque = 1'b1;
            end else begin
                req_valid = 1'b0;
            end
            if (done) begin
                got_done = 1;
                chk({tag, " done cycle"}, cyc, exp_done);
                chk({tag, " done plot"}, plot, 0);
            end
        end
        req_valid  = 1'b0;
        plot_stall = 1'b0;
        if (got_done == 0) chk({tag, " done timeout"}, 0, 1);
        chk({tag, " missing plots"}, exp_q.size(), 0);
        @(negedge clock);
        chk({tag, " done pulse width"}, done, 0);
        chk({tag, " idle busy"}, busy, 0);
        chk({tag, " idle ready"}, req_ready, 1);
        extra_done = 0;
        repeat (4) begin
            @(negedge clock);
            if (done || plot || busy) extra_done++;
        end
        chk({tag, " quiet after done"}, extra_done, 0);
    endtask

    initial begin
        int dcount;
        repeat (3) @(negedge clock);
        #1;
        chk("reset ready", req_ready, 1);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset plot", plot, 0);
        chk("reset glyph_code", glyph_code, 0);
        @(negedge clock);
        resetn = 1'b1;

        run("single",  2, 10, 20, 6, 0, 0, 0, 0, 0, 0);
        run("solid_x2", 1, 10, 20, 3, 0, 0, 1, 0, 0, 0);
        run("blank_opq", 0, 40, 50, 1, 5, 1, 0, 0, 0, 0);
        run("blank_tr", 0, 40, 50, 1, 5, 0, 0, 0, 0, 0);
        run("stall", 1, 0, 0, 4, 0, 0, 0, 6, 3, 0);
        run("wrap", 1, 250, 124, 7, 0, 0, 0, 0, 0, 0);
        run("inject", 2, 30, 40, 2, 6, 1, 0, 0, 0, 10);

        // Reset in the middle of drawing a solid glyph.
        @(negedge clock);
        req_valid = 1'b1; req_char = 8'd1; req_x = 8'd5; req_y = 7'd5;
        req_fg = 3'd7; req_opaque = 1'b0; req_scale = 2'd0;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        repeat (10) @(negedge clock);
        chk("pre-reset plot", plot, 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("mid reset plot", plot, 0);
        chk("mid reset busy", busy, 0);
        chk("mid reset ready", req_ready, 1);
        chk("mid reset glyph_code", glyph_code, 0);
        dcount = 0;
        repeat (3) begin
            @(negedge clock);
            if (done) dcount++;
        end
        resetn = 1'b1;
        repeat (5) begin
            @(negedge clock);
            if (done || busy) dcount++;
        end
        chk("no done after reset", dcount, 0);

        run("after_reset_x4", 2, 100, 60, 5, 1, 1, 3, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
